plantard_premul: RTL

Iterative first stage of the Plantard modular multiplier. It computes C = (A · W) mod 2^(2·LOGQ), where W = B · Q⁻¹ mod 2^(2·LOGQ) is supplied precomputed, and presents C to the shift-based reduction stage that follows it. The stage consumes A one DIGIT-bit slice per cycle, which trades latency for a small multiplier. Operands enter and the product leaves over valid/ready handshakes, so the block can throttle the reduction pipeline and be throttled by it.

---
 rtl/plantard_pkg.sv | 24 ++
 rtl/plantard_premul_pe.sv | 23 ++
 rtl/plantard_premul.sv | 120 ++++++++++++
 3 files changed

// File: rtl/plantard_pkg.sv
`default_nettype none
// ============================================================================
// plantard_pkg : shared FSM type and elaboration helpers for plantard_premul
// Revision     : 1.0
// ============================================================================
package plantard_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } plantard_premul_state_t;

    // Number of DIGIT-wide slices of A, i.e. BUSY cycles without zero skip.
    function automatic int plantard_premul_lat(input int logq, input int digit);
        return logq / digit;
    endfunction

    function automatic bit plantard_premul_digit_ok(input int logq, input int digit);
        return (digit > 0) && (digit <= logq) && ((logq % digit) == 0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/plantard_premul_pe.sv
`default_nettype none
// ============================================================================
// plantard_premul_pe : acc + digit*w, truncated to 2*LOGQ bits (combinational)
// Revision           : 1.0
// ============================================================================
module plantard_premul_pe #(
    parameter int LOGQ  = 64,
    parameter int DIGIT = 16
) (
    input  logic [2*LOGQ-1:0] i_acc,
    input  logic [DIGIT-1:0]  i_digit,
    input  logic [2*LOGQ-1:0] i_w,
    output logic [2*LOGQ-1:0] o_sum
);

    logic [2*LOGQ-1:0] w_digit_ext;

    assign w_digit_ext = {{(2*LOGQ-DIGIT){1'b0}}, i_digit};
    // Evaluated in a 2*LOGQ-bit context, so carries past the top bit are dropped.
    assign o_sum       = i_acc + (w_digit_ext * i_w);

endmodule
`default_nettype wire

// File: rtl/plantard_premul.sv
`default_nettype none
// ============================================================================
// plantard_premul : iterative C = A*W mod 2^(2*LOGQ), DIGIT bits of A per cycle
// Revision        : 1.0   (option macro: PLANTARD_PREMUL_ZERO_SKIP_EN)
// ============================================================================
module plantard_premul
    import plantard_pkg::*;
#(
    parameter int LOGQ  = 64,
    parameter int DIGIT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  logic [LOGQ-1:0]   i_a,
    input  logic [2*LOGQ-1:0] i_w,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [2*LOGQ-1:0] o_c
);

    localparam int c_N_DIGITS = plantard_premul_lat(LOGQ, DIGIT);
    localparam int c_CNT_W    = (c_N_DIGITS > 1) ? $clog2(c_N_DIGITS) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(c_N_DIGITS - 1);

    if (!plantard_premul_digit_ok(LOGQ, DIGIT)) begin : g_bad_digit
        $error("plantard_premul: DIGIT must divide LOGQ");
    end

    plantard_premul_state_t r_state;
    logic [LOGQ-1:0]        r_a;
    logic [2*LOGQ-1:0]      r_w;
    logic [2*LOGQ-1:0]      r_acc;
    logic [c_CNT_W-1:0]     r_cnt;
    logic                   r_out_valid;

    logic [2*LOGQ-1:0]      w_acc_next;
    logic [LOGQ-1:0]        w_a_shift;
    logic                   w_last;
    logic                   w_in_hs;

    plantard_premul_pe #(
        .LOGQ  (LOGQ),
        .DIGIT (DIGIT)
    ) u_pe (
        .i_acc   (r_acc),
        .i_digit (r_a[DIGIT-1:0]),
        .i_w     (r_w),
        .o_sum   (w_acc_next)
    );

    assign w_a_shift = r_a >> DIGIT;

`ifdef PLANTARD_PREMUL_ZERO_SKIP_EN
    // Remaining slices of A are all zero: further steps would add nothing.
    assign w_last = (r_cnt == c_LAST) || (w_a_shift == '0);
`else
    assign w_last = (r_cnt == c_LAST);
`endif

    assign o_in_ready  = (r_state == IDLE) || ((r_state == DONE) && i_out_ready);
    assign w_in_hs     = i_in_valid && o_in_ready;
    assign o_out_valid = r_out_valid;
    assign o_c         = r_acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_a         <= '0;
            r_w         <= '0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_in_hs) begin
                        r_state <= BUSY;
                        r_a     <= i_a;
                        r_w     <= i_w;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                    end
                end
                BUSY: begin
                    r_acc <= w_acc_next;
                    r_a   <= w_a_shift;
                    r_w   <= r_w << DIGIT;
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_state     <= DONE;
                        r_out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (i_out_ready) begin
                        r_out_valid <= 1'b0;
                        // Result leaves and new operands enter on the same edge.
                        if (w_in_hs) begin
                            r_state <= BUSY;
                            r_a     <= i_a;
                            r_w     <= i_w;
                            r_acc   <= '0;
                            r_cnt   <= '0;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
